// File: rtl/folded_maj_pkg.sv
`default_nettype none
// ============================================================================
// Module      : folded_maj_pkg
// Description : Shared types, mode encodings and beat-geometry helpers for the
//               folded threshold unit.
// Revision    : 1.0 - initial release
// ============================================================================
package folded_maj_pkg;

    typedef enum logic [0:0] {
        ACC  = 1'b0,
        RESP = 1'b1
    } state_t;

    localparam logic MODE_MAJ = 1'b0;
    localparam logic MODE_THR = 1'b1;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int beats_of(input int n, input int w);
        return ceil_div(n, w);
    endfunction

    // Number of live vote bits carried by the final beat of a vector
    function automatic int last_bits_of(input int n, input int w);
        return n - (ceil_div(n, w) - 1) * w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/folded_threshold_unit_popcount_w.sv
`default_nettype none
// ============================================================================
// Module      : popcount_w
// Description : Combinational population count of one W-bit beat.
// Revision    : 1.0 - initial release
// ============================================================================
module popcount_w #(
    parameter int W  = 16,
    parameter int PW = $clog2(W + 1)
) (
    input  logic [W-1:0]  i_bits,
    output logic [PW-1:0] o_count
);

    always_comb begin
        o_count = '0;
        for (int i = 0; i < W; i++) begin
            o_count = o_count + PW'(i_bits[i]);
        end
    end

endmodule
`default_nettype wire

// File: rtl/folded_threshold_unit.sv
`default_nettype none
// ============================================================================
// Module      : folded_threshold_unit
// Description : Folded majority / threshold gate; accumulates the popcount of
//               an N-bit vote vector over ceil(N/W) beats of W bits.
// Revision    : 1.0 - initial release
// ============================================================================
module folded_threshold_unit
    import folded_maj_pkg::*;
#(
    parameter int N  = 255,
    parameter int W  = 16,
    parameter int CW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    input  logic          mode,
    input  logic [CW-1:0] thr,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_y,
    output logic [CW-1:0] out_count
);

    localparam int C_BEATS     = beats_of(N, W);
    localparam int C_LAST_BITS = last_bits_of(N, W);
    localparam int C_BCW       = (C_BEATS > 1) ? clog2(C_BEATS) : 1;
    localparam int C_PW        = $clog2(W + 1);

    localparam logic [C_BCW-1:0] C_LAST_IDX  = C_BCW'(C_BEATS - 1);
    localparam logic [W-1:0]     C_LAST_MASK = {W{1'b1}} >> (W - C_LAST_BITS);
    // count > floor(N/2) is the strict majority for both odd and even N
    localparam logic [CW-1:0]    C_MAJ_HALF  = CW'(N / 2);

    state_t             r_state;
    state_t             w_state_next;
    logic [C_BCW-1:0]   r_beat_cnt;
    logic [CW-1:0]      r_acc;
    logic               r_mode;
    logic [CW-1:0]      r_thr;
    logic               r_y;
    logic [CW-1:0]      r_count;

    logic               w_accept;
    logic               w_first;
    logic               w_last;
    logic [W-1:0]       w_masked;
    logic [C_PW-1:0]    w_pc;
    logic [CW-1:0]      w_acc_next;
    logic               w_mode_eff;
    logic [CW-1:0]      w_thr_eff;
    logic               w_decision;

    assign w_accept = in_valid && (r_state == ACC);
    assign w_first  = (r_beat_cnt == '0);
    assign w_last   = (r_beat_cnt == C_LAST_IDX);
    assign w_masked = w_last ? (in_data & C_LAST_MASK) : in_data;

    popcount_w #(
        .W  (W),
        .PW (C_PW)
    ) u_popcount (
        .i_bits  (w_masked),
        .o_count (w_pc)
    );

    assign w_acc_next = (w_first ? '0 : r_acc) + CW'(w_pc);

    // Single-beat vectors decide on the same cycle mode/thr are captured
    assign w_mode_eff = w_first ? mode : r_mode;
    assign w_thr_eff  = w_first ? thr  : r_thr;
    assign w_decision = (w_mode_eff == MODE_THR) ? (w_acc_next >= w_thr_eff)
                                                 : (w_acc_next >  C_MAJ_HALF);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ACC;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            ACC: begin
                in_ready = 1'b1;
                if (w_accept && w_last) begin
                    w_state_next = RESP;
                end
            end
            RESP: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = ACC;
                end
            end
            default: w_state_next = ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_beat_cnt <= '0;
            r_acc      <= '0;
            r_mode     <= 1'b0;
            r_thr      <= '0;
            r_y        <= 1'b0;
            r_count    <= '0;
        end else if (w_accept) begin
            r_acc <= w_acc_next;
            if (w_first) begin
                r_mode <= mode;
                r_thr  <= thr;
            end
            if (w_last) begin
                r_beat_cnt <= '0;
                r_count    <= w_acc_next;
                r_y        <= w_decision;
            end else begin
                r_beat_cnt <= r_beat_cnt + C_BCW'(1);
            end
        end
    end

    assign out_y     = r_y;
    assign out_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_folded_threshold_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_folded_threshold_unit
// Description : Scoreboard bench for folded_threshold_unit (N=255, W=16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_folded_threshold_unit;

    localparam int N  = 255;
    localparam int W  = 16;
    localparam int CW = 8;
    localparam int BEATS = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic          mode = 1'b0;
    logic [CW-1:0] thr = '0;
    logic          out_valid;
    logic          out_ready;
    logic          out_y;
    logic [CW-1:0] out_count;

    logic fixed_ready = 1'b1;
    logic rand_en     = 1'b0;
    logic rand_ready  = 1'b1;
    assign out_ready = rand_en ? rand_ready : fixed_ready;

    int n_checks = 0;
    int n_errors = 0;
    int exp_cnt_q[$];
    logic exp_y_q[$];

    folded_threshold_unit #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .mode      (mode),
        .thr       (thr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        rand_ready = 1'($urandom_range(0, 1));
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic ref_decision(input int cnt, input logic m, input int t);
        if (m) return cnt >= t;
        if (N % 2 == 1) return cnt >= (N + 1) / 2;
        return cnt > N / 2;
    endfunction

    function automatic logic [255:0] ones_vec(input int n);
        logic [255:0] v;
        v = '0;
        for (int i = 0; i < n; i++) v[i] = 1'b1;
        return v;
    endfunction

    // Scoreboard monitor: compares each result at its handshake
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_cnt_q.size() == 0) begin
                chk("unexpected_result", 1, 0);
            end else begin
                chk("out_count", int'(out_count), exp_cnt_q.pop_front());
                chk("out_y", int'(out_y), int'(exp_y_q.pop_front()));
            end
        end
    end

    task automatic send_beat(input logic [W-1:0] d, input logic m, input logic [CW-1:0] t);
        int budget;
        budget   = 0;
        in_valid = 1'b1;
        in_data  = d;
        mode     = m;
        thr      = t;
        @(negedge clk);
        while (!in_ready && budget < 1000) begin
            budget++;
            @(negedge clk);
        end
        if (!in_ready) chk("in_ready_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic send_vector(input logic [255:0] v, input logic m, input logic [CW-1:0] t,
                               input int gap_pct);
        int cnt;
        cnt = $countones(v[254:0]);
        exp_cnt_q.push_back(cnt);
        exp_y_q.push_back(ref_decision(cnt, m, int'(t)));
        for (int k = 0; k < BEATS; k++) begin
            while (gap_pct > 0 && int'($urandom_range(0, 99)) < gap_pct) begin
                in_valid = 1'b0;
                in_data  = W'($urandom);
                @(posedge clk);
                #1;
            end
            if (k == 0) send_beat(v[k*W +: W], m, t);
            else        send_beat(v[k*W +: W], 1'($urandom), CW'($urandom));
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("latency_out_valid", int'(out_valid), 1);
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while (exp_cnt_q.size() != 0 && budget < 2000) begin
            budget++;
            @(posedge clk);
        end
        if (exp_cnt_q.size() != 0) chk("drain_timeout", exp_cnt_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [255:0] v;
        int           exp_c;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_in_ready", int'(in_ready), 1);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_out_y", int'(out_y), 0);
        chk("reset_out_count", int'(out_count), 0);
        @(posedge clk);
        #1;

        send_vector('0, 1'b0, '0, 0);
        send_vector(ones_vec(128), 1'b0, '0, 0);
        send_vector(ones_vec(127), 1'b0, '0, 0);
        v = '0;
        v[255:240] = 16'hFFFF;
        send_vector(v, 1'b0, '0, 0);
        send_vector(ones_vec(200), 1'b1, 8'd200, 0);
        send_vector(ones_vec(199), 1'b1, 8'd200, 0);
        send_vector('0, 1'b1, 8'd0, 0);
        send_vector({1'b1, ones_vec(255)}, 1'b1, 8'd255, 0);
        send_vector(ones_vec(254), 1'b1, 8'd255, 0);
        drain();

        // Backpressure: result must hold and input must stay blocked
        fixed_ready = 1'b0;
        v = ones_vec(150);
        exp_c = 150;
        send_vector(v, 1'b0, '0, 0);
        in_valid = 1'b1;
        in_data  = 16'hFFFF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_out_valid", int'(out_valid), 1);
            chk("stall_in_ready", int'(in_ready), 0);
            chk("stall_out_count", int'(out_count), exp_c);
            chk("stall_out_y", int'(out_y), 1);
        end
        @(posedge clk);
        #1;
        in_valid    = 1'b0;
        fixed_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("release_in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;
        send_vector(ones_vec(40), 1'b0, '0, 0);
        send_vector(ones_vec(40), 1'b0, '0, 60);
        drain();

        // Mid-vector reset discards the partial accumulation
        for (int k = 0; k < 7; k++) send_beat(16'hFFFF, 1'b1, 8'd3);
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_in_ready", int'(in_ready), 1);
        chk("rst_mid_out_valid", int'(out_valid), 0);
        chk("rst_mid_out_y", int'(out_y), 0);
        chk("rst_mid_out_count", int'(out_count), 0);
        @(posedge clk);
        #1;
        v = '0;
        for (int k = 0; k < BEATS; k++) v[k*W] = 1'b1;
        send_vector(v, 1'b0, '0, 0);
        drain();

        rand_en = 1'b1;
        for (int n = 0; n < 40; n++) begin
            for (int j = 0; j < 8; j++) v[j*32 +: 32] = $urandom;
            case ($urandom_range(0, 3))
                0: for (int j = 0; j < 8; j++) v[j*32 +: 32] = v[j*32 +: 32] & $urandom;
                1: for (int j = 0; j < 8; j++) v[j*32 +: 32] = v[j*32 +: 32] | $urandom;
                default: ;
            endcase
            send_vector(v, 1'($urandom), CW'($urandom), int'($urandom_range(0, 40)));
        end
        drain();
        rand_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire
